// File: rtl/nota_entrada_pkg.sv
// Shared definitions for the note-entry path: note codes, press FSM states, FIFO token
// layout and the seven-segment table (also used by the downstream recognizer).
package nota_entrada_pkg;

  typedef enum logic [2:0] {
    NotaX   = 3'd0,
    NotaDo  = 3'd1,
    NotaRe  = 3'd2,
    NotaMi  = 3'd3,
    NotaFa  = 3'd4,
    NotaSol = 3'd5,
    NotaLa  = 3'd6,
    NotaSi  = 3'd7
  } nota_e;

  typedef enum logic [1:0] {
    StIdle,
    StArming,
    StHeld,
    StReleasing
  } press_st_e;

  typedef struct packed {
    logic       tom;
    logic [2:0] nota;
  } token_t;

  localparam logic [6:0] SegBlank = 7'b0000000;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg_of(logic [2:0] nota);
    logic [6:0] seg;
    case (nota)
      NotaX:   seg = 7'b0111111;
      NotaDo:  seg = 7'b0000110;
      NotaRe:  seg = 7'b1011011;
      NotaMi:  seg = 7'b1001111;
      NotaFa:  seg = 7'b1100110;
      NotaSol: seg = 7'b1101101;
      NotaLa:  seg = 7'b1111101;
      NotaSi:  seg = 7'b0000111;
      default: seg = SegBlank;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// Press debouncer: accepts a level change on the synchronized button only after
// DEBOUNCE_CYCLES consecutive equal samples, and emits one capture pulse per accepted press.
module debounce_botao
  import nota_entrada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ok_i,
  output logic capture_o
);

  localparam logic [7:0] Target = 8'(DEBOUNCE_CYCLES);

  press_st_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       capture_q, capture_d;

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ok_i) begin
          state_d = StArming;
          cnt_d   = 8'd1;
        end
      end
      StArming: begin
        if (ok_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == Target) begin
            state_d   = StHeld;
            capture_d = 1'b1;
          end
        end else begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end
      end
      StHeld: begin
        if (!ok_i) begin
          state_d = StReleasing;
          cnt_d   = 8'd1;
        end
      end
      StReleasing: begin
        if (!ok_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == Target) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
          end
        end else begin
          // Bounce during release: the button is still considered held.
          state_d = StHeld;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      capture_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      capture_q <= capture_d;
    end
  end

  assign capture_o = capture_q;

endmodule

// File: rtl/nota_entrada.sv
// Note entry front end: synchronizes the raw switches, debounces the confirm button,
// queues {tom, nota} tokens for the recognizer and drives the seven-segment display.
module nota_entrada
  import nota_entrada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ok,
  input  logic       tom,
  input  logic [2:0] nota,
  input  logic       clr,
  output logic [2:0] nota_out,
  output logic       tom_out,
  output logic       valid,
  input  logic       ready,
  output logic       overflow,
  output logic [6:0] display
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic          ok_meta_q, ok_meta_d, ok_sync_q, ok_sync_d;
  logic          tom_meta_q, tom_meta_d, tom_sync_q, tom_sync_d;
  logic [2:0]    nota_meta_q, nota_meta_d, nota_sync_q, nota_sync_d;
  token_t        mem_q [FIFO_DEPTH];
  token_t        mem_d [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          overflow_q, overflow_d;
  logic [6:0]    display_q, display_d;
  logic          capture, empty, full, pop, push;
  token_t        head, in_tok;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (reset),
    .ok_i     (ok_sync_q),
    .capture_o(capture)
  );

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty  = (wptr_q == rptr_q);
  assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head   = mem_q[rptr_q[AW-1:0]];
  assign in_tok = {tom_sync_q, nota_sync_q};
  assign pop    = !empty && ready && !clr;
  assign push   = capture && !clr && (!full || pop);

  always_comb begin
    ok_meta_d   = ok;
    ok_sync_d   = ok_meta_q;
    tom_meta_d  = tom;
    tom_sync_d  = tom_meta_q;
    nota_meta_d = nota;
    nota_sync_d = nota_meta_q;
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q;
    display_d   = display_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = in_tok;
      wptr_d                = wptr_q + PtrOne;
    end
    if (pop) begin
      rptr_d = rptr_q + PtrOne;
    end
    if (clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      overflow_d = 1'b0;
    end else if (capture && full && !pop) begin
      overflow_d = 1'b1;
    end
    // Dropped or cleared presses still show what the player pressed.
    if (capture) begin
      display_d = seg_of(nota_sync_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ok_meta_q   <= 1'b0;
      ok_sync_q   <= 1'b0;
      tom_meta_q  <= 1'b0;
      tom_sync_q  <= 1'b0;
      nota_meta_q <= 3'd0;
      nota_sync_q <= 3'd0;
      mem_q       <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      display_q   <= SegBlank;
    end else begin
      ok_meta_q   <= ok_meta_d;
      ok_sync_q   <= ok_sync_d;
      tom_meta_q  <= tom_meta_d;
      tom_sync_q  <= tom_sync_d;
      nota_meta_q <= nota_meta_d;
      nota_sync_q <= nota_sync_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      display_q   <= display_d;
    end
  end

  assign valid    = !empty;
  assign nota_out = valid ? head.nota : 3'd0;
  assign tom_out  = valid ? head.tom : 1'b0;
  assign overflow = overflow_q;
  assign display  = display_q;

endmodule

// File: tb/tb_nota_entrada.sv
// Bench for nota_entrada: a run-length press model plus a token queue predict every output
// each cycle; scenario tasks add fixed expectations for latency, ordering and flags.
module tb_nota_entrada;

  localparam int D     = 16;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic       tom;
    logic [2:0] nota;
  } tok_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       ok    = 1'b0;
  logic       tom   = 1'b0;
  logic [2:0] nota  = 3'd0;
  logic       clr   = 1'b0;
  logic       ready = 1'b0;
  logic [2:0] nota_out;
  logic       tom_out, valid, overflow;
  logic [6:0] display;

  int errors   = 0;
  int checks   = 0;
  int dut_pops = 0;

  logic [6:0] seg_ref [8] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111};

  nota_entrada #(
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ok      (ok),
    .tom     (tom),
    .nota    (nota),
    .clr     (clr),
    .nota_out(nota_out),
    .tom_out (tom_out),
    .valid   (valid),
    .ready   (ready),
    .overflow(overflow),
    .display (display)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset && valid && ready && !clr) dut_pops++;

  // Reference model: raw inputs reach the press logic two edges late; a press is accepted
  // after D consecutive samples opposite to the accepted level; the token lands one edge later.
  tok_t       mq[$];
  logic       m_ovf  = 1'b0;
  logic [6:0] m_disp = 7'b0;
  logic [4:0] h1 = 5'b0, h2 = 5'b0, m_seen = 5'b0;
  logic       m_lvl = 1'b0, m_cap = 1'b0, m_pop = 1'b0;
  int         m_run = 0, m_sz = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_ovf = 1'b0; m_disp = 7'b0; h1 = 5'b0; h2 = 5'b0;
      m_lvl = 1'b0; m_cap = 1'b0; m_run = 0;
    end else begin
      m_seen = h2;
      h2     = h1;
      h1     = {ok, tom, nota};
      if (clr) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        m_sz  = mq.size();
        m_pop = (m_sz > 0) && ready;
        if (m_pop) void'(mq.pop_front());
        if (m_cap) begin
          if (m_sz < DEPTH || m_pop) mq.push_back(tok_t'(m_seen[3:0]));
          else m_ovf = 1'b1;
        end
      end
      if (m_cap) m_disp = seg_ref[m_seen[2:0]];
      m_cap = 1'b0;
      if (m_seen[4] == m_lvl) m_run = 0;
      else begin
        m_run++;
        if (m_run == D) begin
          m_lvl = !m_lvl;
          m_run = 0;
          m_cap = m_lvl;
        end
      end
    end
  end

  wire [12:0] dut_vec = {valid, valid ? {tom_out, nota_out} : 4'b0, overflow, display};

  function automatic logic [12:0] model_vec();
    logic [3:0] h = 4'b0;
    if (mq.size() > 0) h = mq[0];
    return {mq.size() > 0, h, m_ovf, m_disp};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec !== 13'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", dut_vec, 13'b0);
    end
    checks++;
    if ({nota_out, tom_out} !== 4'b0) begin
      errors++; $display("FAIL reset_token: got %b want 0000", {nota_out, tom_out});
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL reset_idle: got %b want %b", dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    int vcycles, first_v, p0;
    logic [2:0] seen;
    ready = 1'b1; nota = 3'd6; tom = 1'b0;
    @(negedge clk);
    ok = 1'b1; p0 = dut_pops; vcycles = 0; first_v = -1; seen = 3'd0;
    for (int i = 0; i < 2 * D + 12; i++) begin
      if (i == D + 8) ok = 1'b0;
      @(negedge clk); checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL clean_press_cycle: got %b want %b", dut_vec, model_vec());
      end
      if (valid) begin
        vcycles++;
        if (first_v < 0) begin first_v = i; seen = nota_out; end
      end
    end
    checks++;
    if (vcycles != 1) begin errors++; $display("FAIL clean_valid_cycles: got %0d want 1", vcycles); end
    checks++;
    if (first_v != D + 2) begin errors++; $display("FAIL clean_latency: got %0d want %0d", first_v, D + 2); end
    checks++;
    if (seen !== 3'd6) begin errors++; $display("FAIL clean_nota: got %0d want 6", seen); end
    checks++;
    if (display !== 7'b1111101) begin errors++; $display("FAIL clean_display: got %b want 1111101", display); end
    checks++;
    if (dut_pops - p0 != 1) begin errors++; $display("FAIL clean_pushes: got %0d want 1", dut_pops - p0); end
  endtask

  task automatic test_bounce();
    int p0;
    ready = 1'b1; nota = 3'd3; tom = 1'b1; p0 = dut_pops;
    for (int i = 0; i < 30 + 40 + D + 8; i++) begin
      ok = (i < 30) ? ((i % 6) < 3) : (i < 70);
      @(negedge clk); checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL bounce_cycle: got %b want %b", dut_vec, model_vec());
      end
    end
    checks++;
    if (dut_pops - p0 != 1) begin errors++; $display("FAIL bounce_pushes: got %0d want 1", dut_pops - p0); end
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      nota = 3'(k); tom = k[0];
      for (int i = 0; i < 2 * D + 12; i++) begin
        ok = (i < D + 6);
        @(negedge clk); checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL overflow_cycle: got %b want %b", dut_vec, model_vec());
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b want 1", overflow); end
    checks++;
    if (display !== 7'b1101101) begin errors++; $display("FAIL overflow_display: got %b want 1101101", display); end
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (valid !== 1'b1 || nota_out !== 3'(k + 1)) begin
        errors++; $display("FAIL overflow_pop_order: got v=%b n=%0d want v=1 n=%0d", valid, nota_out, k + 1);
      end
      @(negedge clk);
    end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL overflow_drained: got %b want 0", valid); end
  endtask

  task automatic test_full_push_pop();
    logic [2:0] exp_order [4] = '{3'd2, 3'd3, 3'd4, 3'd7};
    ready = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      nota = (k == 5) ? 3'd7 : 3'(k); tom = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 2 * D + 12; i++) begin
        if (i == D + 6) ok = 1'b0;
        @(negedge clk); checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL fullpp_cycle: got %b want %b", dut_vec, model_vec());
        end
        // Pop exactly on the edge where the fifth press lands.
        ready = (k == 5) && (i == D + 1);
      end
    end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow: got %b want 0", overflow); end
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (valid !== 1'b1 || nota_out !== exp_order[k]) begin
        errors++; $display("FAIL fullpp_order: got v=%b n=%0d want v=1 n=%0d", valid, nota_out, exp_order[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL fullpp_occupancy: got %b want 0", valid); end
  endtask

  task automatic test_reset_mid();
    int p0;
    ready = 1'b1; nota = 3'd2; tom = 1'b0; p0 = dut_pops;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    reset = 1'b0; ok = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 13'b0) begin errors++; $display("FAIL midreset_outputs: got %b want 0", dut_vec); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL midreset_cycle: got %b want %b", dut_vec, model_vec());
      end
    end
    checks++;
    if (dut_pops != p0) begin errors++; $display("FAIL midreset_nopush: got %0d want 0", dut_pops - p0); end
    ok = 1'b1;
    for (int i = 0; i < 2 * D + 12; i++) begin
      if (i == D + 8) ok = 1'b0;
      @(negedge clk); checks++;
      if (dut_vec !== model_vec()) begin
        errors++; $display("FAIL midreset_repress: got %b want %b", dut_vec, model_vec());
      end
    end
    checks++;
    if (dut_pops - p0 != 1) begin errors++; $display("FAIL midreset_onepush: got %0d want 1", dut_pops - p0); end
  endtask

  task automatic test_clr();
    logic [2:0] notes [5] = '{3'd4, 3'd1, 3'd6, 3'd3, 3'd5};
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      nota = notes[k]; tom = 1'b1;
      for (int i = 0; i < 2 * D + 12; i++) begin
        ok = (i < D + 6);
        @(negedge clk); checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL clr_fill: got %b want %b", dut_vec, model_vec());
        end
      end
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (valid !== 1'b1 || overflow !== 1'b1 || nota_out !== 3'd1) begin
      errors++; $display("FAIL clr_precond: got v=%b o=%b n=%0d want v=1 o=1 n=1", valid, overflow, nota_out);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL clr_flags: got v=%b o=%b want v=0 o=0", valid, overflow);
    end
    checks++;
    if (display !== 7'b1101101) begin errors++; $display("FAIL clr_display: got %b want 1101101", display); end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 50; r++) begin
      len = $urandom_range(1, 2 * D + 4);
      ok  = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        tom   = 1'($urandom_range(0, 1));
        nota  = 3'($urandom_range(0, 7));
        ready = ($urandom_range(0, 3) != 0);
        clr   = ($urandom_range(0, 60) == 0);
        @(negedge clk); checks++;
        if (dut_vec !== model_vec()) begin
          errors++; $display("FAIL random_cycle: got %b want %b", dut_vec, model_vec());
        end
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_clr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/nota_entrada.md
NOTA_ENTRADA -- requirements
Module: nota_entrada

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, is the number of consecutive stable synchronized samples required to accept a level change on ok (legal range 2..255).
REQ-002 Parameter FIFO_DEPTH, default 4, is the number of buffered note tokens (power of two, 2..16).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 ok  input  1  raw asynchronous note-confirm push button, active-high, bouncy.
REQ-006 tom  input  1  raw asynchronous modifier switch, 1 = altered note.
REQ-007 nota  input  3  raw asynchronous note switches; 0 = pause/x, 1..7 = do..si.
REQ-008 clr  input  1  synchronous clear of FIFO and overflow flag.
REQ-009 nota_out  output  3  note field of the FIFO head token.
REQ-010 tom_out  output  1  modifier field of the FIFO head token.
REQ-011 valid  output  1  FIFO head token is present.
REQ-012 ready  input  1  downstream recognizer accepts the head token this cycle.
REQ-013 overflow  output  1  sticky flag: a press was dropped because the FIFO was full.
REQ-014 display  output  7  seven-segment pattern {g,f,e,d,c,b,a}, active-high, of the last captured note.

Function
REQ-015 ok, tom and nota SHALL each pass through a two-flop synchronizer before any other use.
REQ-016 Press FSM states: IDLE, ARMING, HELD, RELEASING.
REQ-017 IDLE: synchronized ok = 1 -> ARMING with counter loaded to 1; else stay.
REQ-018 ARMING: ok = 1 increments counter; on reaching DEBOUNCE_CYCLES -> HELD and issue one capture pulse; ok = 0 -> IDLE.
REQ-019 HELD: ok = 0 -> RELEASING with counter loaded to 1; else stay (no repeat captures while held).
REQ-020 RELEASING: ok = 0 increments counter; on reaching DEBOUNCE_CYCLES -> IDLE; ok = 1 -> HELD.
REQ-021 The capture pulse SHALL push {tom_sync, nota_sync}, sampled in the same cycle, into the FIFO.
REQ-022 Latency: with a clean ok edge, the push occurs DEBOUNCE_CYCLES + 2 cycles after the first clk edge that samples ok high; valid rises the cycle after the push.
REQ-023 A pop occurs when valid && ready; nota_out/tom_out SHALL be stable while valid && !ready.
REQ-024 Push while full and no pop: the token is dropped, FIFO unchanged, overflow set to 1.
REQ-025 Push and pop in the same cycle while full: both take effect, occupancy unchanged, overflow not set.
REQ-026 Push and pop in the same cycle while empty cannot occur (valid = 0); the push lands and valid = 1 next cycle.
REQ-027 Read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full = MSBs differ with lower bits equal.
REQ-028 clr = 1 empties the FIFO and clears overflow next edge, does not affect press FSM or display; a push coincident with clr is discarded.
REQ-029 display SHALL update on every capture pulse (including dropped ones): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111.

Reset
REQ-030 reset low SHALL immediately force: FSM IDLE, counter 0, synchronizers 0, FIFO empty, valid 0, nota_out 0, tom_out 0, overflow 0, display 0000000 (blank).
REQ-031 reset asserted mid-debounce or mid-hold SHALL abandon the press; after release a new full 0->1 debounce is required before the next capture.

Structure
REQ-032 Note codes (nota_x, do..si), FSM state encoding and the segment table SHALL live in a shared package, also used by the downstream recognizer.
REQ-033 Debounce FSM plus counter SHALL be a sub-module named debounce_botao producing the one-cycle capture pulse; synchronizers and FIFO remain in nota_entrada.

Verification
REQ-034 Clean press, nota=6, tom=0, ready=1, DEBOUNCE_CYCLES=16 -> single push, valid high one cycle with nota_out=6, display=1111101.
REQ-035 ok bouncing 5 times (3-cycle pulses) then stable high 40 cycles -> exactly one token pushed.
REQ-036 ready=0, 5 presses (notas 1..5) -> FIFO holds 1,2,3,4; overflow=1; display=1101101; then ready=1 -> pops 1,2,3,4 in order.
REQ-037 FIFO full, ready=1 and a capture in the same cycle -> occupancy stays 4, overflow stays 0.
REQ-038 reset pulsed low at count 8 of ARMING with ok held high -> no push; release and re-press yields exactly one push.
REQ-039 clr=1 while 3 tokens queued and overflow=1 -> valid=0 and overflow=0 next cycle, display unchanged.
